// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller in front of a word-addressed synchronous
// data memory (combinational read, write on rising clk).
// It accepts byte-addressed requests over a valid/ready handshake.
// Byte and halfword stores are done as read-modify-write.
// Each request ends with a one-cycle resp_valid pulse that carries either the
// extended load data or an error flag.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    request handshake
//   req_we, req_size,      request kind (store/load), size (00 byte, 01 half,
//   req_signed             10 word), and sign-extension for loads
//   req_addr, req_wdata    byte address, right-aligned store data
//   resp_valid/_rdata/_err completion pulse, load result, error flag
//   mem_a, mem_din,        memory word address and write data
//   mem_dout               memory read data
//   mem_mread, mem_mwrite  memory strobes
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; next state chosen on acceptance
// LOAD    | read the word, extract and extend the lane into rdata_q
// WSTORE  | full-word write of the latched data
// RMW_RD  | read the word into merge_q
// RMW_WR  | write merge_q with the selected lane replaced
// RESP    | resp_valid pulse, no error
// ERR     | resp_valid pulse with resp_err, no memory access was made
module lsu_ctrl #(
  parameter int L  = 256,
  parameter int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout,
  output logic          mem_mread,
  output logic          mem_mwrite
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WSTORE, S_RMW_RD, S_RMW_WR, S_RESP, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [1:0]    boff_q, boff_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          accept;
  logic          req_err;
  logic [4:0]    sh;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;
  logic [31:0]   lane_mask;
  logic [31:0]   lane_ins;
  logic [31:0]   merged;

  assign accept  = req_valid && (state_q == S_IDLE);
  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_addr[31:AW+2] != '0);

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    sh = {boff_q, 3'b000};
    case (boff_q)
      2'd0:    byte_sel = mem_dout[7:0];
      2'd1:    byte_sel = mem_dout[15:8];
      2'd2:    byte_sel = mem_dout[23:16];
      default: byte_sel = mem_dout[31:24];
    endcase
    half_sel = boff_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sgn_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_dout;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << sh;
      lane_ins  = {24'h0, wdata_q[7:0]} << sh;
    end else begin
      lane_mask = 32'h0000_FFFF << sh;
      lane_ins  = {16'h0, wdata_q[15:0]} << sh;
    end
    merged = (merge_q & ~lane_mask) | (lane_ins & lane_mask);
  end

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    boff_d     = boff_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_a      = '0;
    mem_din    = 32'h0;
    mem_mread  = 1'b0;
    mem_mwrite = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          waddr_d = req_addr[AW+1:2];
          boff_d  = req_addr[1:0];
          size_d  = req_size;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          // Cleared so that stores respond with zero data.
          rdata_d = 32'h0;
          if (req_err)                state_d = S_ERR;
          else if (!req_we)           state_d = S_LOAD;
          else if (req_size == 2'b10) state_d = S_WSTORE;
          else                        state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_mread = 1'b1;
        mem_a     = waddr_q;
        rdata_d   = load_ext;
        state_d   = S_RESP;
      end
      S_WSTORE: begin
        mem_mwrite = 1'b1;
        mem_a      = waddr_q;
        mem_din    = wdata_q;
        state_d    = S_RESP;
      end
      S_RMW_RD: begin
        mem_mread = 1'b1;
        mem_a     = waddr_q;
        merge_d   = mem_dout;
        state_d   = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_mwrite = 1'b1;
        mem_a      = waddr_q;
        mem_din    = merged;
        state_d    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      boff_q  <= 2'b00;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      boff_q  <= boff_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: attached memory model, byte-level reference model,
// directed scenarios followed by randomized requests.
module tb_lsu_ctrl;
  localparam int L  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic          mem_mread;
  logic          mem_mwrite;

  int total = 0;
  int bad   = 0;

  logic [31:0] dmem [L];
  logic [7:0]  ref_b [4*L];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          idle_viol = 0;
  logic [AW-1:0] last_wa = '0;
  logic [31:0]   last_wd = 32'h0;
  logic [31:0]   last_rd;
  logic          last_err;

  lsu_ctrl #(.L(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_mread(mem_mread), .mem_mwrite(mem_mwrite)
  );

  always #5 clk = ~clk;

  assign mem_dout = dmem[mem_a];
  always @(posedge clk) if (mem_mwrite) dmem[mem_a] <= mem_din;

  always @(negedge clk) begin
    if (mem_mwrite) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_a;
      last_wd <= mem_din;
    end
    if (mem_mread) rd_cnt <= rd_cnt + 1;
    if (!mem_mwrite && !mem_mread && (mem_a != '0 || mem_din != 32'h0))
      idle_viol <= idle_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, alignment as address modulo size.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd);
    int nb;
    logic [63:0] v;
    nb  = 1 << sz;
    err = (sz == 2'd3) || ((a % nb) != 0) || (a >= 4*L);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_b[a+i] = wd[8*i +: 8];
      end else begin
        v = 64'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[a+i];
        if (sg && v[8*nb-1])
          for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        rd = v[31:0];
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  req_ready,  1);
    chk({tag, "_rvalid"}, resp_valid, 0);
    chk({tag, "_rerr"},   resp_err,   0);
    chk({tag, "_rdata"},  resp_rdata, 0);
    chk({tag, "_mem_a"},  mem_a,      0);
    chk({tag, "_din"},    mem_din,    0);
    chk({tag, "_mread"},  mem_mread,  0);
    chk({tag, "_mwrite"}, mem_mwrite, 0);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        exp_err;
    logic [31:0] exp_rd;
    int lat, w0, r0, n, exp_lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", req_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs to show the request was latched.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    w0 = wr_cnt; r0 = rd_cnt;
    model(we, sz, sg, a, wd, exp_err, exp_rd);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 8);
    last_rd  = resp_rdata;
    last_err = resp_err;
    exp_lat = exp_err ? 1 : ((!we || sz == 2'd2) ? 2 : 3);
    chk("latency",    lat,        exp_lat);
    chk("resp_err",   resp_err,   exp_err);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("ready_busy", req_ready,  0);
    chk("mwrite_cnt", wr_cnt - w0, (we && !exp_err) ? 1 : 0);
    chk("mread_cnt",  rd_cnt - r0, (!exp_err && (!we || sz != 2'd2)) ? 1 : 0);
  endtask

  initial begin
    logic [31:0] v;
    logic        e;
    logic [31:0] r;
    int w0, nresp, n, mism;

    for (int i = 0; i < L; i++) begin
      v = (i == 4) ? 32'h8899AABB : $urandom;
      dmem[i] <= v;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = v[8*k +: 8];
    end

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Loads from word 4 = 0x8899AABB
    do_req(0, 2'd0, 1, 32'h11, 32'h0);
    chk("sb_load", last_rd, 32'hFFFFFFAA);
    do_req(0, 2'd0, 0, 32'h11, 32'h0);
    chk("ub_load", last_rd, 32'h000000AA);
    do_req(0, 2'd1, 0, 32'h12, 32'h0);
    chk("uh_load", last_rd, 32'h00008899);
    do_req(0, 2'd1, 1, 32'h12, 32'h0);
    chk("sh_load", last_rd, 32'hFFFF8899);

    // Reset during RMW_RD of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    chk("rmw_rd_mread", mem_mread, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    nresp = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) nresp++; end
    chk("rst_no_resp",  nresp, 0);
    chk("rst_no_write", wr_cnt - w0, 0);
    chk("rst_word4",    dmem[4], 32'h8899AABB);

    // Byte store then word load
    do_req(1, 2'd0, 0, 32'h13, 32'h5C);
    chk("bst_mem_a", last_wa, 4);
    chk("bst_din",   last_wd, 32'h5C99AABB);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    chk("bst_readback", last_rd, 32'h5C99AABB);

    // Error cases
    do_req(0, 2'd2, 0, 32'h22, 32'h0);
    chk("err_wmis", last_err, 1);
    do_req(1, 2'd1, 0, 32'h11, 32'hFFFF);
    chk("err_hmis", last_err, 1);
    do_req(0, 2'd3, 0, 32'h10, 32'h0);
    chk("err_size", last_err, 1);
    do_req(0, 2'd2, 0, 32'h400, 32'h0);
    chk("err_range", last_err, 1);

    // Back-to-back: word store with a load queued behind it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    model(1, 2'd2, 0, 32'h20, 32'hDEADBEEF, e, r);
    req_we = 1'b0; req_wdata = $urandom;
    @(negedge clk);
    chk("b2b_ready_c1", req_ready, 0);
    @(negedge clk);
    chk("b2b_ready_c2", req_ready, 0);
    chk("b2b_resp_c2",  resp_valid, 1);
    @(negedge clk);
    chk("b2b_ready_c3", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(0, 2'd2, 0, 32'h20, 32'h0, e, r);
    @(negedge clk);
    chk("b2b_load_c1", resp_valid, 0);
    @(negedge clk);
    chk("b2b_load_c2", resp_valid, 1);
    chk("b2b_rdata",   resp_rdata, 32'hDEADBEEF);

    // Randomized requests
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int rs;
      rs = $urandom_range(0, 9);
      if (rs == 0)      a = $urandom;
      else if (rs == 1) a = 32'($urandom_range(1016, 1023));
      else              a = 32'($urandom_range(0, 127));
      rs = $urandom_range(0, 9);
      sz = (rs == 9) ? 2'd3 : 2'(rs % 3);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    mism = 0;
    for (int i = 0; i < L; i++)
      if (dmem[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]})
        mism++;
    chk("mem_contents", mism, 0);
    chk("idle_bus_zero", idle_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that sits directly upstream of the synchronous data memory (256 × 32-bit, word-addressed, combinational read, write on rising `clk` when `mwrite`=1). It accepts byte-addressed load/store requests from the CPU datapath through a valid/ready handshake. It converts them into word accesses, performing read-modify-write for byte and halfword stores. It returns a sign- or zero-extended load result, or an error flag, through a one-cycle response pulse.

## Interface
- `L`, 256, number of 32-bit words in the attached data memory.
- `AW`, `$clog2(L)`, memory word-address width (8 at default).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal and raises an error.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned access, out-of-range address, or illegal size; valid with `resp_valid`.
- `mem_a`  out  AW  word address = `req_addr[AW+1:2]`.
- `mem_din`  out  32  write data to memory.
- `mem_dout`  in  32  combinational read data from memory.
- `mem_mread`  out  1  read strobe (informational).
- `mem_mwrite`  out  1  write enable.

## Operation
- Byte order is little-endian.
  - Byte lane k = `addr[1:0]` occupies bits [8k+7:8k].
  - Halfword lane h = `addr[1]` occupies bits [16h+15:16h].
- Request fields are latched into internal registers on acceptance (`req_valid && req_ready`). Later changes to the inputs have no effect on the accepted request.
- Error conditions, checked at acceptance:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `req_size`=11;
  - `req_addr[31:AW+2]`≠0.
- An errored request performs no memory access: `mem_mwrite` and `mem_mread` stay 0.
- FSM states and transitions:
  - IDLE: `req_ready`=1. On acceptance, the next state is ERR if an error condition holds; otherwise LOAD for loads, WSTORE for word stores, or RMW_RD for byte/halfword stores.
  - LOAD: `mem_mread`=1, `mem_a` taken from the latched address. At the clock edge, extract the lane from `mem_dout`, extend it, and register it into the result. Next state: RESP.
  - WSTORE: `mem_mwrite`=1, `mem_din` = latched wdata. Next state: RESP.
  - RMW_RD: `mem_mread`=1. At the clock edge, capture `mem_dout` into the merge register. Next state: RMW_WR.
  - RMW_WR: `mem_mwrite`=1, `mem_din` = merge register with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`. Next state: RESP.
  - RESP: `resp_valid`=1, `resp_err`=0. Next state: IDLE.
  - ERR: `resp_valid`=1, `resp_err`=1, `resp_rdata`=0. Next state: IDLE.
- `req_ready` is 0 in every state except IDLE.
- Each accepted store produces exactly one `mem_mwrite` cycle.
- Outputs are decoded from registered state only; there is no combinational path from `req_*` to any `mem_*` output.
- `mem_a` and `mem_din` are 0 whenever no strobe is asserted.

## Timing
- Reset (`rst_n`=0, asynchronous): state = IDLE, with all latched and result registers cleared.
  - Output values during reset: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_a`=0, `mem_din`=0, `mem_mread`=0, `mem_mwrite`=0.
- Reset asserted mid-operation, including RMW_RD: the request is abandoned, no response is produced, and no `mem_mwrite` is issued afterwards.
- Latency is counted from the accepting edge E0 to the cycle in which `resp_valid` is high:
  - load: 2 cycles (LOAD, then RESP);
  - word store: 2 cycles;
  - byte/halfword store: 3 cycles;
  - error: 1 cycle.
- A new request can be accepted on the edge that returns the FSM to IDLE plus one, so the back-to-back throughput is one request per (latency + 1) cycles.
- For an RMW store, memory is written on the edge that ends RMW_WR. A load issued afterwards therefore sees the merged word.

## Test plan
- Setup: memory word 4 (byte address 0x10) preloaded with 0x8899AABB.
- Signed byte load at 0x11 → `resp_rdata`=0xFFFFFFAA, `resp_err`=0, `resp_valid` high 2 cycles after acceptance. Unsigned byte load at 0x11 → 0x000000AA.
- Unsigned halfword load at 0x12 → 0x00008899. Signed halfword load at 0x12 → 0xFFFF8899.
- Byte store of 0x5C to 0x13 → exactly one `mem_mwrite` pulse with `mem_a`=4 and `mem_din`=0x5C99AABB. A following word load at 0x10 → 0x5C99AABB.
- Word load at 0x22, halfword store to 0x11, `req_size`=11, and word load at 0x400 (L=256) → each gives `resp_err`=1 and `resp_rdata`=0 one cycle after acceptance, with no `mem_mwrite` or `mem_mread` activity.
- Halfword store of 0x1234 to 0x10, with `rst_n` pulsed low during RMW_RD → word 4 remains 0x8899AABB, there is no `resp_valid`, and all outputs read their reset values.
- Back-to-back: word store 0xDEADBEEF to 0x20 with `req_valid` held high and a load from 0x20 queued → the load is accepted only after RESP completes, `req_ready`=0 during the busy cycles, and the load returns 0xDEADBEEF.
